pc_fetch_unit: RTL and testbench

//  Owns the architectural PC and the fetch side of the pipeline. Consumes the next-PC redirect produced by
//  the branch control logic, issues requests to instruction memory and presents fetched instructions to

---
 rtl/pc_fetch_unit_pkg.sv | 23 ++
 rtl/pc_fetch_unit_if.sv | 31 +++
 rtl/pc_fetch_unit_pc_incr.sv | 21 ++
 rtl/pc_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module  : pc_fetch_unit_pkg
// Purpose : Shared types and constants for the instruction fetch unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

  localparam int              c_WORD_W      = 16;
  localparam logic [15:0]     c_RESET_PC    = 16'h0000;
  localparam logic [3:0]      c_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module  : pc_fetch_unit_if
// Purpose : Instruction-memory read bus between the fetch unit and imem.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic                imem_req;
  logic [c_WORD_W-1:0] imem_addr;
  logic                imem_rdy;
  logic [c_WORD_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_incr.sv
// ============================================================================
// Module  : pc_incr
// Purpose : Fixed +2 incrementer for the program counter (wraps mod 2^16).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_incr
  import pc_fetch_unit_pkg::*;
(
  input  wire logic [c_WORD_W-1:0] i_a,
  output logic      [c_WORD_W-1:0] o_sum
);

  localparam logic [c_WORD_W-1:0] c_STEP = 16'h0002;

  assign o_sum = i_a + c_STEP;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module  : pc_fetch_unit
// Purpose : Owns the PC, issues imem reads and hands words to decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = c_RESET_PC,
  parameter logic [3:0]  HALT_OPCODE = c_HALT_OPCODE
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_stall,
  input  wire logic                i_redirect_valid,
  input  wire logic [c_WORD_W-1:0] i_redirect_pc,
  pc_fetch_unit_if.master          imem,
  output logic                     o_if_valid,
  output logic      [c_WORD_W-1:0] o_if_instr,
  output logic      [c_WORD_W-1:0] o_if_pc,
  output logic      [c_WORD_W-1:0] o_if_pc_plus2,
  output logic                     o_halted
);

  fetch_state_t        r_state, w_state_next;
  logic [c_WORD_W-1:0] r_pc, w_pc_next, w_pc_plus2;
  logic                r_imem_req, w_req_next;
  logic [c_WORD_W-1:0] r_imem_addr, w_addr_next;
  logic                r_if_valid, w_if_valid_next;
  logic [c_WORD_W-1:0] r_if_instr, r_if_pc, r_if_pc_plus2;
  logic                r_halted, w_halted_next;
  logic                r_squash, w_squash_next;
  logic                w_load;

  pc_incr u_pc_incr (
    .i_a   (r_pc),
    .o_sum (w_pc_plus2)
  );

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_next      = 1'b0;
    w_addr_next     = r_imem_addr;
    w_if_valid_next = r_if_valid;
    w_halted_next   = r_halted;
    w_squash_next   = r_squash;
    w_load          = 1'b0;

    if (r_if_valid && !i_stall) begin
      w_if_valid_next = 1'b0;
    end

    if (i_redirect_valid) begin
      w_pc_next       = {i_redirect_pc[c_WORD_W-1:1], 1'b0};
      w_if_valid_next = 1'b0;
      if (r_state == ST_WAIT && !imem.imem_rdy) begin
        // Word still in flight: remember to drop it when it lands.
        w_squash_next = 1'b1;
      end else begin
        w_state_next  = ST_FETCH;
        w_squash_next = 1'b0;
        w_halted_next = 1'b0;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (!(i_stall && r_if_valid)) begin
            w_req_next   = 1'b1;
            w_addr_next  = r_pc;
            w_state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_rdy) begin
            if (r_squash) begin
              w_squash_next = 1'b0;
              w_state_next  = ST_FETCH;
            end else begin
              w_load          = 1'b1;
              w_if_valid_next = 1'b1;
              w_pc_next       = w_pc_plus2;
              if (imem.imem_rdata[c_WORD_W-1:c_WORD_W-4] == HALT_OPCODE) begin
                w_state_next  = ST_HALT;
                w_halted_next = 1'b1;
              end else if (i_stall) begin
                w_state_next = ST_HOLD;
              end else begin
                w_state_next = ST_FETCH;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            w_state_next = ST_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus2 <= '0;
      r_halted      <= 1'b0;
      r_squash      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_imem_req  <= w_req_next;
      r_imem_addr <= w_addr_next;
      r_if_valid  <= w_if_valid_next;
      r_halted    <= w_halted_next;
      r_squash    <= w_squash_next;
      if (w_load) begin
        r_if_instr    <= imem.imem_rdata;
        r_if_pc       <= r_pc;
        r_if_pc_plus2 <= w_pc_plus2;
      end
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_imem_addr;
  assign o_if_valid     = r_if_valid;
  assign o_if_instr     = r_if_instr;
  assign o_if_pc        = r_if_pc;
  assign o_if_pc_plus2  = r_if_pc_plus2;
  assign o_halted       = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module  : tb_pc_fetch_unit
// Purpose : Directed self-checking bench for pc_fetch_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;

  int n_checks;
  int n_fail;

  // Memory responder state and single-word override
  logic        pending;
  logic [15:0] paddr;
  logic        ovr_en;
  logic [15:0] ovr_addr;
  logic [15:0] ovr_data;

  pc_fetch_unit_if u_if ();

  pc_fetch_unit u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .imem             (u_if),
    .o_if_valid       (if_valid),
    .o_if_instr       (if_instr),
    .o_if_pc          (if_pc),
    .o_if_pc_plus2    (if_pc_plus2),
    .o_halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return {4'h1, a[11:0]};
  endfunction

  // Answers each one-cycle request with rdy exactly one cycle later.
  initial begin
    u_if.imem_rdy   = 1'b0;
    u_if.imem_rdata = 16'h0000;
    pending = 1'b0;
    paddr   = 16'h0000;
    forever begin
      @(negedge clk);
      u_if.imem_rdy = 1'b0;
      if (pending) begin
        u_if.imem_rdy   = 1'b1;
        u_if.imem_rdata = mem_word(paddr);
        pending         = 1'b0;
      end
      if (u_if.imem_req) begin
        pending = 1'b1;
        paddr   = u_if.imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [15:0] exp_addr);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!u_if.imem_req && n < 10);
    chk({tag, "_req"}, {31'd0, u_if.imem_req}, 32'd1);
    chk({tag, "_addr"}, {16'd0, u_if.imem_addr}, {16'd0, exp_addr});
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_instr);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!if_valid && n < 10);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, {16'd0, if_pc}, {16'd0, exp_pc});
    chk({tag, "_pc2"}, {16'd0, if_pc_plus2}, {16'd0, exp_pc + 16'd2});
    chk({tag, "_instr"}, {16'd0, if_instr}, {16'd0, exp_instr});
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    ovr_en         = 1'b0;
    ovr_addr       = 16'h0000;
    ovr_data       = 16'h0000;

    tick();
    tick();
    chk("rst_req",    {31'd0, u_if.imem_req}, 32'd0);
    chk("rst_addr",   {16'd0, u_if.imem_addr}, 32'd0);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_instr",  {16'd0, if_instr}, 32'd0);
    chk("rst_pc",     {16'd0, if_pc}, 32'd0);
    chk("rst_pc2",    {16'd0, if_pc_plus2}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Sequential fetch 0000, 0002, 0004
    for (int k = 0; k < 3; k++) begin
      wait_req("seq", 16'(2 * k));
      wait_valid("seq", 16'(2 * k), {4'h1, 12'(2 * k)});
      chk("seq_halted", {31'd0, halted}, 32'd0);
    end

    // Stall holds 1234 at pc 0006
    ovr_en   = 1'b1;
    ovr_addr = 16'h0006;
    ovr_data = 16'h1234;
    wait_req("stl", 16'h0006);
    stall = 1'b1;
    wait_valid("stl", 16'h0006, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stl_hold_instr", {16'd0, if_instr}, 32'h1234);
      chk("stl_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("stl_hold_noreq", {31'd0, u_if.imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stl_consumed", {31'd0, if_valid}, 32'd0);
    wait_req("stl_next", 16'h0008);

    // Redirect during WAIT drops the outstanding word
    redirect(16'h0040);
    chk("sq_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    chk("sq_valid1", {31'd0, if_valid}, 32'd0);
    wait_req("sq", 16'h0040);
    wait_valid("sq", 16'h0040, 16'h1040);

    // HALT at 0006, then resume via redirect (bit0 dropped)
    ovr_data = 16'hF000;
    redirect(16'h0006);
    wait_req("hlt", 16'h0006);
    wait_valid("hlt", 16'h0006, 16'hF000);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hlt_noreq", {31'd0, u_if.imem_req}, 32'd0);
    end
    chk("hlt_valid_drop", {31'd0, if_valid}, 32'd0);
    chk("hlt_still", {31'd0, halted}, 32'd1);
    redirect(16'h0011);
    chk("hlt_resume", {31'd0, halted}, 32'd0);
    wait_req("hlt_next", 16'h0010);
    wait_valid("hlt_next", 16'h0010, 16'h1010);

    // PC wrap at FFFE
    redirect(16'hFFFE);
    wait_req("wrap", 16'hFFFE);
    wait_valid("wrap", 16'hFFFE, 16'h1FFE);
    chk("wrap_pc2", {16'd0, if_pc_plus2}, 32'h0000);
    wait_req("wrap_next", 16'h0000);

    // Reset in WAIT; late rdy must be ignored
    redirect(16'h0020);
    wait_req("rw", 16'h0020);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req0",   {31'd0, u_if.imem_req}, 32'd0);
    chk("rw_valid0", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rw_valid1", {31'd0, if_valid}, 32'd0);
    chk("rw_req1",   {31'd0, u_if.imem_req}, 32'd1);
    chk("rw_addr1",  {16'd0, u_if.imem_addr}, 32'h0000);
    wait_valid("rw", 16'h0000, 16'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
